// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-port memory arbiter.
package mem_arb_pkg;

  localparam int ARB_RR      = 0;
  localparam int ARB_FIXED_B = 1;

  typedef struct packed {
    logic [3:0]  we;
    logic [31:0] addr;
    logic [31:0] wdata;
  } port_req_t;

  typedef enum logic [1:0] {
    SEL_NONE,
    SEL_A,
    SEL_B
  } sel_e;

  typedef enum logic {
    LAST_A,
    LAST_B
  } last_e;

endpackage

// File: rtl/mem_arb_rsp.sv
// One response slot: holds rvalid/rdata until consumed, reloads on a new grant.
module mem_arb_rsp (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_load,
  input  logic [31:0] i_load_data,
  input  logic        i_rready,
  output logic        o_rvalid,
  output logic [31:0] o_rdata
);

  logic        r_rvalid;
  logic [31:0] r_rdata;

  // A load wins over a drain so back-to-back responses keep rvalid high.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_rvalid <= 1'b0;
      r_rdata  <= '0;
    end else if (i_load) begin
      r_rvalid <= 1'b1;
      r_rdata  <= i_load_data;
    end else if (r_rvalid && i_rready) begin
      r_rvalid <= 1'b0;
    end
  end

  assign o_rvalid = r_rvalid;
  assign o_rdata  = r_rdata;

endmodule

// File: rtl/mem_arbiter.sv
// Two-port (A = fetch, B = data) arbiter onto a single-cycle RAM, with
// round-robin or fixed-B priority and a one-deep response slot per port.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ARB_MODE = ARB_RR
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        a_req,
  input  logic [3:0]  a_we,
  input  logic [31:0] a_addr,
  input  logic [31:0] a_wdata,
  output logic        a_gnt,
  output logic        a_rvalid,
  output logic [31:0] a_rdata,
  input  logic        a_rready,
  input  logic        b_req,
  input  logic [3:0]  b_we,
  input  logic [31:0] b_addr,
  input  logic [31:0] b_wdata,
  output logic        b_gnt,
  output logic        b_rvalid,
  output logic [31:0] b_rdata,
  input  logic        b_rready,
  output logic        ram_r,
  output logic [3:0]  ram_w,
  output logic [31:0] ram_addr,
  output logic [31:0] ram_in,
  input  logic [31:0] ram_out
);

  // Handshake: req/gnt is a request accepted in the cycle both are high; the
  // requester holds its fields while req=1 and gnt=0. rvalid/rready is a
  // response transferred in the cycle both are high; rvalid/rdata hold until then.
  // A port may only be granted when its response slot is free or draining.
  port_req_t   w_a;
  port_req_t   w_b;
  port_req_t   w_req;
  sel_e        w_sel;
  last_e       r_last;
  logic        w_a_elig;
  logic        w_b_elig;
  logic [31:0] w_rsp_data;

  assign w_a = '{we: a_we, addr: a_addr, wdata: a_wdata};
  assign w_b = '{we: b_we, addr: b_addr, wdata: b_wdata};

  assign w_a_elig = a_req && (!a_rvalid || a_rready);
  assign w_b_elig = b_req && (!b_rvalid || b_rready);

  always_comb begin
    w_sel = SEL_NONE;
    if (!reset) begin
      if (w_a_elig && w_b_elig) begin
        if (ARB_MODE == ARB_FIXED_B) begin
          w_sel = SEL_B;
        end else begin
          w_sel = (r_last == LAST_B) ? SEL_A : SEL_B;
        end
      end else if (w_a_elig) begin
        w_sel = SEL_A;
      end else if (w_b_elig) begin
        w_sel = SEL_B;
      end
    end
  end

  // Reset leaves the pointer at "B last" so A wins the first tie.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_last <= LAST_B;
    end else if (w_sel == SEL_A) begin
      r_last <= LAST_A;
    end else if (w_sel == SEL_B) begin
      r_last <= LAST_B;
    end
  end

  always_comb begin
    w_req = '0;
    case (w_sel)
      SEL_A:   w_req = w_a;
      SEL_B:   w_req = w_b;
      default: w_req = '0;
    endcase
  end

  assign a_gnt    = (w_sel == SEL_A);
  assign b_gnt    = (w_sel == SEL_B);
  assign ram_w    = w_req.we;
  assign ram_addr = w_req.addr;
  assign ram_in   = w_req.wdata;
  assign ram_r    = (w_sel != SEL_NONE) && (w_req.we == 4'b0000);

  // Writes complete with zero data; reads return what the RAM presents now.
  assign w_rsp_data = ram_r ? ram_out : '0;

  mem_arb_rsp u_rsp_a (
    .i_clk       (clk),
    .i_reset     (reset),
    .i_load      (a_gnt),
    .i_load_data (w_rsp_data),
    .i_rready    (a_rready),
    .o_rvalid    (a_rvalid),
    .o_rdata     (a_rdata)
  );

  mem_arb_rsp u_rsp_b (
    .i_clk       (clk),
    .i_reset     (reset),
    .i_load      (b_gnt),
    .i_load_data (w_rsp_data),
    .i_rready    (b_rready),
    .o_rvalid    (b_rvalid),
    .o_rdata     (b_rdata)
  );

endmodule

// File: tb/tb_mem_arbiter.sv
// Drives a round-robin and a fixed-B arbiter with shared stimulus and checks
// both against a cycle-level behavioural model of the arbitration rules.
module tb_mem_arbiter;
  import mem_arb_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        ram_clr;
  logic        a_req, b_req, a_rready, b_rready;
  logic [3:0]  a_we, b_we;
  logic [31:0] a_addr, b_addr, a_wdata, b_wdata;

  logic [1:0]       gnt_a, gnt_b, rv_a, rv_b, ram_r;
  logic [1:0][31:0] rd_a, rd_b, ram_addr, ram_in, ram_out;
  logic [1:0][3:0]  ram_w;

  int n_tests = 0;
  int n_fail  = 0;

  // Model state, index 0 = round-robin instance, 1 = fixed-B instance.
  bit          m_last_b [2];
  bit          m_rv     [2][2];
  logic [31:0] m_rd     [2][2];
  logic [31:0] m_mem    [2][16];
  int          win      [2];
  bit          hold_a, hold_b;
  logic        obs_ga [2], obs_gb [2], obs_rr [2];
  logic [3:0]  obs_rw [2];
  logic [31:0] obs_ra [2];

  always #5 clk = ~clk;

  for (genvar d = 0; d < 2; d++) begin : g_dut
    logic [31:0] mem [16];

    mem_arbiter #(.ARB_MODE(d)) u_dut (
      .clk      (clk),
      .reset    (reset),
      .a_req    (a_req),
      .a_we     (a_we),
      .a_addr   (a_addr),
      .a_wdata  (a_wdata),
      .a_gnt    (gnt_a[d]),
      .a_rvalid (rv_a[d]),
      .a_rdata  (rd_a[d]),
      .a_rready (a_rready),
      .b_req    (b_req),
      .b_we     (b_we),
      .b_addr   (b_addr),
      .b_wdata  (b_wdata),
      .b_gnt    (gnt_b[d]),
      .b_rvalid (rv_b[d]),
      .b_rdata  (rd_b[d]),
      .b_rready (b_rready),
      .ram_r    (ram_r[d]),
      .ram_w    (ram_w[d]),
      .ram_addr (ram_addr[d]),
      .ram_in   (ram_in[d]),
      .ram_out  (ram_out[d])
    );

    assign ram_out[d] = mem[ram_addr[d][5:2]];

    always @(negedge clk) begin
      if (ram_clr) begin
        for (int i = 0; i < 16; i++) mem[i] <= '0;
      end else begin
        for (int i = 0; i < 4; i++)
          if (ram_w[d][i]) mem[ram_addr[d][5:2]][8*i +: 8] <= ram_in[d][8*i +: 8];
      end
    end
  end

  task automatic check(input int d, input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL dut%0d %s observed=%h expected=%h", d, tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [3:0] we,
                                        input logic [31:0] data);
    logic [31:0] r;
    r = old;
    for (int i = 0; i < 4; i++) if (we[i]) r[8*i +: 8] = data[8*i +: 8];
    return r;
  endfunction

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      m_last_b[d] = 1'b1;
      for (int p = 0; p < 2; p++) begin
        m_rv[d][p] = 1'b0;
        m_rd[d][p] = '0;
      end
      for (int i = 0; i < 16; i++) m_mem[d][i] = '0;
    end
  endtask

  // Called 1 time unit after a posedge with inputs already set; checks this
  // cycle mid-phase, then advances the model across the next posedge.
  task automatic do_cycle();
    logic [3:0]  ewe;
    logic [31:0] ead, ewd;
    bit          ea, eb;
    #3;
    for (int d = 0; d < 2; d++) begin
      ea = !reset && a_req && (!m_rv[d][0] || a_rready);
      eb = !reset && b_req && (!m_rv[d][1] || b_rready);
      if (ea && eb)  win[d] = (d == ARB_FIXED_B) ? 2 : (m_last_b[d] ? 1 : 2);
      else if (ea)   win[d] = 1;
      else if (eb)   win[d] = 2;
      else           win[d] = 0;
      ewe = (win[d] == 1) ? a_we    : (win[d] == 2) ? b_we    : 4'h0;
      ead = (win[d] == 1) ? a_addr  : (win[d] == 2) ? b_addr  : 32'h0;
      ewd = (win[d] == 1) ? a_wdata : (win[d] == 2) ? b_wdata : 32'h0;
      obs_ga[d] = gnt_a[d];
      obs_gb[d] = gnt_b[d];
      obs_rr[d] = ram_r[d];
      obs_rw[d] = ram_w[d];
      obs_ra[d] = ram_addr[d];
      check(d, "a_gnt",    gnt_a[d],    32'(win[d] == 1));
      check(d, "b_gnt",    gnt_b[d],    32'(win[d] == 2));
      check(d, "ram_r",    ram_r[d],    32'(win[d] != 0 && ewe == 4'h0));
      check(d, "ram_w",    ram_w[d],    32'(ewe));
      check(d, "ram_addr", ram_addr[d], ead);
      check(d, "ram_in",   ram_in[d],   ewd);
      check(d, "a_rvalid", rv_a[d],     32'(m_rv[d][0]));
      check(d, "a_rdata",  rd_a[d],     m_rd[d][0]);
      check(d, "b_rvalid", rv_b[d],     32'(m_rv[d][1]));
      check(d, "b_rdata",  rd_b[d],     m_rd[d][1]);
    end
    hold_a = a_req && (win[0] != 1 || win[1] != 1);
    hold_b = b_req && (win[0] != 2 || win[1] != 2);
    @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      if (reset) begin
        m_last_b[d] = 1'b1;
        for (int p = 0; p < 2; p++) begin
          m_rv[d][p] = 1'b0;
          m_rd[d][p] = '0;
        end
      end else begin
        if (m_rv[d][0] && a_rready) m_rv[d][0] = 1'b0;
        if (m_rv[d][1] && b_rready) m_rv[d][1] = 1'b0;
        if (win[d] == 1) begin
          m_rv[d][0]  = 1'b1;
          m_rd[d][0]  = (a_we == 4'h0) ? m_mem[d][a_addr[5:2]] : 32'h0;
          m_mem[d][a_addr[5:2]] = merge(m_mem[d][a_addr[5:2]], a_we, a_wdata);
          m_last_b[d] = 1'b0;
        end else if (win[d] == 2) begin
          m_rv[d][1]  = 1'b1;
          m_rd[d][1]  = (b_we == 4'h0) ? m_mem[d][b_addr[5:2]] : 32'h0;
          m_mem[d][b_addr[5:2]] = merge(m_mem[d][b_addr[5:2]], b_we, b_wdata);
          m_last_b[d] = 1'b1;
        end
      end
    end
  endtask

  initial begin
    reset = 1'b1; ram_clr = 1'b1;
    a_req = 1'b0; a_we = '0; a_addr = '0; a_wdata = '0; a_rready = 1'b1;
    b_req = 1'b0; b_we = '0; b_addr = '0; b_wdata = '0; b_rready = 1'b1;
    hold_a = 1'b0; hold_b = 1'b0;
    @(posedge clk);
    #1;
    model_reset();
    do_cycle();
    do_cycle();
    reset = 1'b0; ram_clr = 1'b0;

    // Tie with continuous requests: RR alternates starting at A, fixed-B picks B.
    a_req = 1'b1; b_req = 1'b1; a_addr = 32'h4; b_addr = 32'hC;
    for (int i = 0; i < 6; i++) begin
      do_cycle();
      check(0, "rr_a_gnt", obs_ga[0], 32'(i % 2 == 0));
      check(0, "rr_b_gnt", obs_gb[0], 32'(i % 2 == 1));
      if (i < 4) begin
        check(1, "fx_b_gnt", obs_gb[1], 32'd1);
        check(1, "fx_a_gnt", obs_ga[1], 32'd0);
      end
    end

    // Full-word preload, byte write from B, then read from A.
    a_req = 1'b0; b_we = 4'hF; b_addr = 32'h8; b_wdata = 32'h11223344;
    do_cycle();
    b_we = 4'b0010; b_wdata = 32'h0000AA00;
    do_cycle();
    b_req = 1'b0; b_we = 4'h0; a_req = 1'b1; a_we = 4'h0; a_addr = 32'h8;
    do_cycle();
    for (int d = 0; d < 2; d++) begin
      check(d, "bw_rvalid", rv_a[d], 32'd1);
      check(d, "bw_rdata",  rd_a[d], 32'h1122AA44);
    end

    // Backpressure on A: no grant while the slot is full and not draining.
    a_rready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      do_cycle();
      for (int d = 0; d < 2; d++) begin
        check(d, "bp_a_gnt",  obs_ga[d], 32'd0);
        check(d, "bp_rvalid", rv_a[d],   32'd1);
        check(d, "bp_rdata",  rd_a[d],   32'h1122AA44);
      end
    end
    a_rready = 1'b1;
    do_cycle();
    for (int d = 0; d < 2; d++) check(d, "bp_release_gnt", obs_ga[d], 32'd1);

    // Reset while B holds a response; writes requested during reset must not issue.
    a_req = 1'b0; b_req = 1'b1; b_we = 4'h0; b_addr = 32'h8; b_rready = 1'b0;
    do_cycle();
    for (int d = 0; d < 2; d++) check(d, "pre_rst_b_rvalid", rv_b[d], 32'd1);
    reset = 1'b1; a_req = 1'b1; a_we = 4'hF; a_wdata = 32'hCAFEF00D;
    b_we = 4'hF; b_wdata = 32'hDEADBEEF;
    do_cycle();
    for (int d = 0; d < 2; d++) begin
      check(d, "rst_ram_w",    32'(obs_rw[d]), 32'd0);
      check(d, "rst_b_rvalid", rv_b[d],        32'd0);
      check(d, "rst_b_rdata",  rd_b[d],        32'd0);
    end
    reset = 1'b0; a_we = 4'h0; b_we = 4'h0; b_rready = 1'b1;
    do_cycle();
    check(0, "post_rst_tie_a", obs_ga[0], 32'd1);

    // Idle: RAM port quiet and contents untouched.
    a_req = 1'b0; b_req = 1'b0;
    for (int i = 0; i < 5; i++) begin
      do_cycle();
      for (int d = 0; d < 2; d++) begin
        check(d, "idle_ram_r",    32'(obs_rr[d]), 32'd0);
        check(d, "idle_ram_w",    32'(obs_rw[d]), 32'd0);
        check(d, "idle_ram_addr", obs_ra[d],      32'd0);
      end
    end
    for (int i = 0; i < 16; i++) begin
      check(0, "idle_mem", g_dut[0].mem[i], m_mem[0][i]);
      check(1, "idle_mem", g_dut[1].mem[i], m_mem[1][i]);
    end

    // Random traffic; a pending request is held until granted by both instances.
    for (int n = 0; n < 400; n++) begin
      if (!hold_a) begin
        a_req   = 1'($urandom_range(0, 1));
        a_we    = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(0, 15));
        a_addr  = $urandom;
        a_wdata = $urandom;
      end
      if (!hold_b) begin
        b_req   = 1'($urandom_range(0, 1));
        b_we    = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(0, 15));
        b_addr  = $urandom;
        b_wdata = $urandom;
      end
      a_rready = ($urandom_range(0, 3) != 0);
      b_rready = ($urandom_range(0, 3) != 0);
      reset    = ($urandom_range(0, 59) == 0);
      do_cycle();
    end
    reset = 1'b0; a_req = 1'b0; b_req = 1'b0;
    do_cycle();
    for (int i = 0; i < 16; i++) begin
      check(0, "final_mem", g_dut[0].mem[i], m_mem[0][i]);
      check(1, "final_mem", g_dut[1].mem[i], m_mem[1][i]);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter ARB_MODE, default 0; 0 = round-robin, 1 = fixed priority to port B.
REQ-002 clk  input  1  single clock; all state updates on posedge clk.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 a_req  input  1  port A (instruction fetch) access request.
REQ-005 a_we  input  4  port A byte write strobes; 0 = read.
REQ-006 a_addr  input  32  port A byte address.
REQ-007 a_wdata  input  32  port A write data.
REQ-008 a_gnt  output  1  port A request accepted this cycle.
REQ-009 a_rvalid  output  1  port A response valid.
REQ-010 a_rdata  output  32  port A read data.
REQ-011 a_rready  input  1  port A response consumed.
REQ-012 b_req, b_we[4], b_addr[32], b_wdata[32], b_gnt, b_rvalid, b_rdata[32], b_rready SHALL mirror port A, with port B as the data port.
REQ-013 ram_r  output  1  RAM read enable.
REQ-014 ram_w  output  4  RAM byte write strobes.
REQ-015 ram_addr  output  32  RAM address, passed through unmodified.
REQ-016 ram_in  output  32  RAM write data.
REQ-017 ram_out  input  32  RAM read data, combinational from ram_addr/ram_r.

Function
REQ-018 Eligibility: a port is eligible when req=1 and (rvalid=0 or rready=1).
REQ-019 Grant rule: at most one gnt high per cycle; gnt is combinational from req, rvalid, rready, the arbitration pointer and ARB_MODE.
REQ-020 ARB_MODE=0, both ports eligible: grant the port not granted most recently. Pointer updates on every grant.
REQ-021 ARB_MODE=1, both ports eligible: B always wins. The pointer is unused.
REQ-022 Single eligible port: that port is granted in the same cycle, no bubble.
REQ-023 Grant cycle RAM outputs:
  - ram_addr = granted addr; ram_in = granted wdata; ram_w = granted we.
  - ram_r = 1 when we==0, else 0.
REQ-024 No-grant cycle RAM outputs: ram_r=0, ram_w=0, ram_addr=0, ram_in=0.
REQ-025 Read response: on the posedge ending the grant cycle, the granted port's rdata <= ram_out and rvalid <= 1.
REQ-026 Write response: on that same edge, rvalid <= 1 and rdata <= 0; the RAM commits the write on the negedge inside the grant cycle.
REQ-027 Latency: response valid exactly 1 cycle after gnt. Throughput: 1 access per cycle total.
REQ-028 Response hold: rvalid and rdata stay stable until a cycle with rvalid=1 and rready=1.
REQ-029 Response drain: in a cycle with rvalid=1 and rready=1 and no new grant to that port, rvalid <= 0 on the next edge.
REQ-030 Simultaneous drain and grant: same-cycle drain and new grant to the same port loads the new response; rvalid stays 1.
REQ-031 Requester stability: a requester holds req/we/addr/wdata stable while req=1 and gnt=0. The arbiter need not tolerate changes during this window.
REQ-032 Ordering: a write granted in cycle N is visible to any read granted in cycle N+1 or later, from either port.
REQ-033 Byte strobes pass through unchanged; the arbiter performs no alignment or masking.

Reset
REQ-034 While reset=1, all gnt outputs SHALL be 0 and ram_r=0, ram_w=0.
REQ-035 On a reset edge: a_rvalid=b_rvalid=0, a_rdata=b_rdata=0, and the pointer is set to "B last", so A wins the first tie.
REQ-036 Reset mid-operation drops any pending responses. No RAM write is issued in a reset cycle.

Structure
REQ-037 Shared package mem_arb_pkg SHALL hold:
  - constants ARB_RR=0 and ARB_FIXED_B=1;
  - port request struct {we[4], addr[32], wdata[32]}.
REQ-038 A response-slot sub-module mem_arb_rsp (rvalid/rdata register with load/drain) SHALL be instantiated once per port.
REQ-039 The arbitration pointer and output multiplexing SHALL live in mem_arbiter.

Verification
REQ-040 Round-robin tie (ARB_MODE=0): after reset, a_req=b_req=1 continuously with rready=1 -> gnt alternates A,B,A,B; first grant to A.
REQ-041 Fixed priority (ARB_MODE=1): a_req=b_req=1 for 4 cycles -> b_gnt=1 all 4 cycles, a_gnt=0.
REQ-042 Byte write then read:
  - pre-load word 0x8 = 0x11223344;
  - B writes b_we=4'b0010, b_wdata=0x0000AA00 to address 0x8;
  - next cycle A reads 0x8 -> a_rvalid one cycle later, a_rdata=0x1122AA44.
REQ-043 Backpressure: A read completes with a_rready=0 for 3 cycles -> a_rvalid and a_rdata stable 3 cycles, a_gnt=0 despite a_req=1; a_rready=1 -> grant in same cycle.
REQ-044 Reset mid-operation: assert reset while b_rvalid=1 -> next edge b_rvalid=0, b_rdata=0, ram_w=0 during reset, next tie grants A.
REQ-045 Idle: no req for 5 cycles -> ram_r=0, ram_w=0, ram_addr=0 every cycle; RAM contents unchanged.
